pe_seq_ctrl: RTL

// - Bus-programmable sequencer for pe_core: runs an N-element multiply-accumulate (dot product) with no CPU per element.
// - CPU preloads operand pairs into a local buffer through the SRAM-like port, then writes START.
// - Block clears the accumulator, issues each pair to pe_core, waits for out_vld, latches final pro_sum.
// - Sits behind the same axi2mem bridge as SRAM; drives pe_core directly in place of a CPU-written register file.

---
 rtl/pe_seq_ctrl_if.sv | 14 +
 rtl/pe_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_seq_ctrl_if.sv
// SRAM-like word bus used by pe_seq_ctrl, shared with the axi2mem bridge.
// The master drives request/write fields; the slave returns combinational read data.
interface pe_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  req_i;
  logic [3:0]            wen_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           data_i;
  logic [31:0]           data_o;

  modport master (output req_i, wen_i, addr_i, data_i, input data_o);
  modport slave  (input req_i, wen_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/pe_seq_ctrl.sv
// Bus-programmable dot-product sequencer driving pe_core from a local operand buffer.
// Optional WAIT watchdog is enabled by defining PE_SEQ_TIMEOUT_EN.
module pe_seq_ctrl #(
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pe_seq_ctrl_if.slave       bus,
  output logic               done_o,
  output logic               pe_read_in,
  output logic               pe_mode_sel,
  output logic [7:0]         pe_a,
  output logic [7:0]         pe_b,
  output logic               pe_clr_acc,
  input  logic               pe_out_vld,
  input  logic [23:0]        pe_pro_sum
);

  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e      r_state;
  logic [4:0]  r_len;
  logic [3:0]  r_idx;
  logic [23:0] r_result;
  logic        r_done;
  logic        r_err;
  logic        r_mode_sel;
  logic        r_pe_read_in;
  logic        r_pe_clr_acc;
  logic [7:0]  r_pe_a;
  logic [7:0]  r_pe_b;
  logic [7:0]  r_buf_a [DEPTH];
  logic [7:0]  r_buf_b [DEPTH];

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_addr32;
  logic                  w_wr;
  logic                  w_ctrl_hit;
  logic                  w_len_hit;
  logic                  w_buf_hit;
  logic [IW-1:0]         w_buf_idx;
  logic                  w_start;
  logic                  w_abort;
  logic                  w_clear;
  logic                  w_busy;
  logic [4:0]            w_eff_len;
  logic                  w_last;
  logic [3:0]            w_next_idx;
  logic [31:0]           w_rdata;
  logic                  w_unused_data;

  assign w_addr     = bus.addr_i;
  assign w_addr32   = 32'(w_addr);
  assign w_wr       = bus.req_i && (bus.wen_i != 4'h0);
  assign w_ctrl_hit = (w_addr32 == 32'd0);
  assign w_len_hit  = (w_addr32 == 32'd2);
  assign w_buf_hit  = (w_addr32 >= 32'd16) && (w_addr32 < 32'(16 + DEPTH));
  assign w_buf_idx  = w_addr32[IW-1:0];

  // Abort dominates start when both arrive in the same CTRL write.
  assign w_abort    = w_wr && w_ctrl_hit && bus.data_i[1];
  assign w_start    = w_wr && w_ctrl_hit && bus.data_i[0] && !bus.data_i[1];
  assign w_clear    = w_wr && w_ctrl_hit && bus.data_i[3];
  assign w_busy     = (r_state != S_IDLE);

  assign w_eff_len  = (r_len > DEPTH_L) ? DEPTH_L : r_len;
  assign w_last     = ({1'b0, r_idx} == (w_eff_len - 5'd1));
  assign w_next_idx = r_idx + 4'd1;

  assign w_unused_data = ^bus.data_i[31:16];

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] r_wdog;
  assign done_o = r_done | r_err;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign done_o = r_done;
`endif

  // NOTE: the operand buffer has no reset so it maps onto plain RAM; software always loads it before START.
  always_ff @(posedge clk_i) begin
    if (w_wr && w_buf_hit && !w_busy) begin
      if (bus.wen_i[0]) r_buf_a[w_buf_idx] <= bus.data_i[7:0];
      if (bus.wen_i[1]) r_buf_b[w_buf_idx] <= bus.data_i[15:8];
    end
  end

  // NOTE: every register here uses <= so all state updates see the pre-edge values, whatever the statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_result     <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mode_sel   <= 1'b0;
      r_pe_read_in <= 1'b0;
      r_pe_clr_acc <= 1'b0;
      r_pe_a       <= '0;
      r_pe_b       <= '0;
`ifdef PE_SEQ_TIMEOUT_EN
      r_wdog       <= '0;
`endif
    end else begin
      r_pe_read_in <= 1'b0;
      r_pe_clr_acc <= 1'b0;

      // Clear comes first so a DONE/ERR set later in this block takes priority.
      if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
      end
      if (w_wr && w_len_hit && !w_busy)  r_len      <= bus.data_i[4:0];
      if (w_wr && w_ctrl_hit && !w_busy) r_mode_sel <= bus.data_i[2];

      if (w_abort && w_busy) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_done <= 1'b0;
              r_err  <= 1'b0;
              if (w_eff_len == 5'd0) begin
                r_result <= '0;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_idx        <= '0;
                r_pe_clr_acc <= 1'b1;
                r_state      <= S_CLR;
              end
            end
          end
          S_CLR: begin
            r_pe_read_in <= 1'b1;
            r_pe_a       <= r_buf_a[0];
            r_pe_b       <= r_buf_b[0];
            r_state      <= S_ISSUE;
          end
          S_ISSUE: begin
`ifdef PE_SEQ_TIMEOUT_EN
            r_wdog  <= '0;
`endif
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (pe_out_vld) begin
              if (w_last) begin
                r_result <= pe_pro_sum;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_idx        <= w_next_idx;
                r_pe_read_in <= 1'b1;
                r_pe_a       <= r_buf_a[w_next_idx[IW-1:0]];
                r_pe_b       <= r_buf_b[w_next_idx[IW-1:0]];
                r_state      <= S_ISSUE;
              end
            end
`ifdef PE_SEQ_TIMEOUT_EN
            else if (r_wdog == WD_W'(TIMEOUT_CYC - 1)) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_wdog <= r_wdog + 1'b1;
            end
`endif
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: w_rdata gets a default before any branch so the read mux stays combinational.
  always_comb begin
    w_rdata = '0;
    if (w_buf_hit) begin
      w_rdata = {16'h0, r_buf_b[w_buf_idx], r_buf_a[w_buf_idx]};
    end else begin
      case (w_addr32)
        32'd0:   w_rdata = {29'h0, r_mode_sel, 2'b00};
        32'd1:   w_rdata = {21'h0, r_state, r_idx, 1'b0, r_err, r_done, w_busy};
        32'd2:   w_rdata = {27'h0, r_len};
        32'd3:   w_rdata = {{8{r_result[23]}}, r_result};
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.data_o  = w_rdata;
  assign pe_read_in  = r_pe_read_in;
  assign pe_clr_acc  = r_pe_clr_acc;
  assign pe_mode_sel = r_mode_sel;
  assign pe_a        = r_pe_a;
  assign pe_b        = r_pe_b;

endmodule
